// File: rtl/tag_ctrl.sv
// tag_ctrl: L1 tag-array sequencer with init clear, flush, lookup compare and read-merge-write update
module tag_ctrl #(
  parameter int NUM_WAY  = 8,
  parameter int SET_W    = 7,
  parameter int OFFSET_W = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       lk_req_i,
  output logic                       lk_ready_o,
  input  logic [31:0]                lk_addr_i,
  output logic                       lk_resp_valid_o,
  output logic                       lk_hit_o,
  output logic [$clog2(NUM_WAY)-1:0] lk_hit_way_o,
  output logic [NUM_WAY-1:0]         lk_valid_vec_o,
  output logic [NUM_WAY-1:0]         lk_dirty_vec_o,
  input  logic                       upd_req_i,
  output logic                       upd_ready_o,
  input  logic [31:0]                upd_addr_i,
  input  logic [$clog2(NUM_WAY)-1:0] upd_way_i,
  input  logic                       upd_v_i,
  input  logic                       upd_d_i,
  output logic                       upd_done_o,
  input  logic                       flush_req_i,
  output logic                       init_done_o,
  output logic                       tag_mem_en_o,
  output logic                       tag_rd_wr_o,
  output logic [31:0]                tag_addr_o,
  output logic [32*NUM_WAY-1:0]      tag_wdata_o,
  input  logic [32*NUM_WAY-1:0]      tag_rdata_i
);
  localparam int TAG_W = 32 - OFFSET_W - SET_W;
  localparam int WAY_W = $clog2(NUM_WAY);
  typedef enum logic [2:0] {RST, INIT, IDLE, LK_CMP, UPD_RD, UPD_WR} state_e;
  state_e             state_q, state_d;
  logic [SET_W-1:0]   cnt_q, cnt_d, tag_idx, upd_idx_q;
  logic               init_done_q, init_done_d, upd_done_q, upd_done_d;
  logic [TAG_W-1:0]   lk_tag_q, upd_tag_q;
  logic [WAY_W-1:0]   upd_way_q, hit_way;
  logic               upd_v_q, upd_d_q, serve, lk_acc, upd_acc, resp;
  logic [NUM_WAY-1:0] match, valid_vec, dirty_vec;
  logic [32*NUM_WAY-1:0] merged;
  logic               unused_offset;
  assign unused_offset = ^{lk_addr_i[OFFSET_W-1:0], upd_addr_i[OFFSET_W-1:0]};
  assign serve       = (state_q == IDLE || state_q == LK_CMP) && init_done_q;
  assign upd_ready_o = serve && !flush_req_i;
  assign lk_ready_o  = upd_ready_o && !upd_req_i;
  assign lk_acc      = lk_req_i && lk_ready_o;
  assign upd_acc     = upd_req_i && upd_ready_o;
  assign resp        = state_q == LK_CMP;
  assign init_done_o = init_done_q;
  assign upd_done_o  = upd_done_q;
  assign tag_addr_o  = {{(32-SET_W){1'b0}}, tag_idx};
  // per-way compare of the returned set; the descending scan leaves the lowest matching way
  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      valid_vec[w] = tag_rdata_i[32*w+31];
      dirty_vec[w] = tag_rdata_i[32*w+30];
      match[w]     = valid_vec[w] && tag_rdata_i[32*w+:TAG_W] == lk_tag_q;
      hit_way      = match[w] ? WAY_W'(w) : hit_way;
    end
  end
  assign lk_resp_valid_o = resp;
  assign lk_hit_o        = resp && |match;
  assign lk_hit_way_o    = resp ? hit_way : '0;
  assign lk_valid_vec_o  = resp ? valid_vec : '0;
  assign lk_dirty_vec_o  = resp ? dirty_vec : '0;
  // replace only the target way of the freshly read set
  always_comb begin
    merged = tag_rdata_i;
    for (int w = 0; w < NUM_WAY; w++)
      merged[32*w+:32] = WAY_W'(w) == upd_way_q ? {upd_v_q, upd_d_q, {(30-TAG_W){1'b0}}, upd_tag_q} : tag_rdata_i[32*w+:32];
  end
  // next state, SRAM command and arbitration (flush > update > lookup)
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    upd_done_d  = 1'b0;
    tag_mem_en_o = 1'b0;
    tag_rd_wr_o  = 1'b0;
    tag_idx      = '0;
    tag_wdata_o  = '0;
    case (state_q)
      RST: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        tag_mem_en_o = 1'b1;
        tag_rd_wr_o  = 1'b1;
        tag_idx      = cnt_q;
        cnt_d        = cnt_q + 1'b1;
        state_d      = &cnt_q ? IDLE : INIT;
        init_done_d  = &cnt_q;
      end
      IDLE, LK_CMP: begin
        state_d = IDLE;
        if (flush_req_i) begin
          state_d     = INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (upd_acc) begin
          tag_mem_en_o = 1'b1;
          tag_idx      = upd_addr_i[OFFSET_W+:SET_W];
          state_d      = UPD_WR;
        end else if (lk_acc) begin
          tag_mem_en_o = 1'b1;
          tag_idx      = lk_addr_i[OFFSET_W+:SET_W];
          state_d      = LK_CMP;
        end
      end
      UPD_WR: begin
        tag_mem_en_o = 1'b1;
        tag_rd_wr_o  = 1'b1;
        tag_idx      = upd_idx_q;
        tag_wdata_o  = merged;
        state_d      = IDLE;
        upd_done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counter and captured request fields; reset aborts any operation in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RST;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      upd_done_q  <= 1'b0;
      lk_tag_q    <= '0;
      upd_tag_q   <= '0;
      upd_idx_q   <= '0;
      upd_way_q   <= '0;
      upd_v_q     <= 1'b0;
      upd_d_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      upd_done_q  <= upd_done_d;
      if (lk_acc && !upd_acc && !flush_req_i) lk_tag_q <= lk_addr_i[31-:TAG_W];
      if (upd_acc) begin
        upd_tag_q <= upd_addr_i[31-:TAG_W];
        upd_idx_q <= upd_addr_i[OFFSET_W+:SET_W];
        upd_way_q <= upd_way_i;
        upd_v_q   <= upd_v_i;
        upd_d_q   <= upd_d_i;
      end
    end
  end
endmodule

// File: tb/tb_tag_ctrl.sv
// tb_tag_ctrl: randomized self-checking bench for tag_ctrl against a per-set/per-way reference model
module tb_tag_ctrl;
  logic clk = 0, rst_n = 0;
  logic lk_req = 0, upd_req = 0, flush_req = 0, upd_v = 0, upd_d = 0;
  logic [31:0] lk_addr = 0, upd_addr = 0;
  logic [2:0] upd_way = 0;
  logic lk_ready, lk_resp_valid, lk_hit, upd_ready, upd_done, init_done, tag_mem_en, tag_rd_wr;
  logic [2:0] lk_hit_way;
  logic [7:0] lk_valid_vec, lk_dirty_vec;
  logic [31:0] tag_addr;
  logic [255:0] tag_wdata, tag_rdata;
  logic [255:0] sram [128];
  int total = 0, bad = 0;
  logic rv [128][8];
  logic rd [128][8];
  logic [19:0] rt [128][8];
  logic [19:0] pool [4] = '{20'h00001, 20'h00002, 20'h80000, 20'hFFFFF};

  always #5 clk = ~clk;

  tag_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lk_req_i(lk_req), .lk_ready_o(lk_ready), .lk_addr_i(lk_addr),
    .lk_resp_valid_o(lk_resp_valid), .lk_hit_o(lk_hit), .lk_hit_way_o(lk_hit_way),
    .lk_valid_vec_o(lk_valid_vec), .lk_dirty_vec_o(lk_dirty_vec),
    .upd_req_i(upd_req), .upd_ready_o(upd_ready), .upd_addr_i(upd_addr), .upd_way_i(upd_way),
    .upd_v_i(upd_v), .upd_d_i(upd_d), .upd_done_o(upd_done),
    .flush_req_i(flush_req), .init_done_o(init_done),
    .tag_mem_en_o(tag_mem_en), .tag_rd_wr_o(tag_rd_wr), .tag_addr_o(tag_addr),
    .tag_wdata_o(tag_wdata), .tag_rdata_i(tag_rdata)
  );

  always @(posedge clk)
    if (tag_mem_en) begin
      if (tag_rd_wr) sram[tag_addr[6:0]] <= tag_wdata;
      else tag_rdata <= sram[tag_addr[6:0]];
    end

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_clear();
    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 8; w++) begin
        rv[s][w] = 0; rd[s][w] = 0; rt[s][w] = 0;
      end
  endfunction

  function automatic logic [255:0] ref_line(input int s);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w+:32] = {rv[s][w], rd[s][w], 10'b0, rt[s][w]};
    return l;
  endfunction

  function automatic logic [20:0] ref_lk(input logic [31:0] a);
    int s = int'(a[11:5]);
    logic hit = 0;
    logic [2:0] way = 0;
    logic [7:0] vv, dv;
    for (int w = 7; w >= 0; w--) begin
      vv[w] = rv[s][w];
      dv[w] = rd[s][w];
      if (rv[s][w] && rt[s][w] == a[31:12]) begin hit = 1; way = 3'(w); end
    end
    return {1'b1, hit, way, vv, dv};
  endfunction

  function automatic logic [31:0] rand_addr();
    return {pool[$urandom_range(0, 3)], 7'(8'h50 + $urandom_range(0, 3)), 5'($urandom)};
  endfunction

  task automatic init_seq();
    for (int i = 0; i < 128; i++) begin
      @(negedge clk); #1;
      chk("init_wr", {init_done, lk_ready, upd_ready, tag_mem_en, tag_rd_wr, tag_addr, tag_wdata},
          {3'b000, 2'b11, 32'(i), 256'h0});
    end
    @(negedge clk); #1;
    chk("init_done", {init_done, tag_mem_en}, 2'b10);
    ref_clear();
  endtask

  task automatic do_upd(input logic [31:0] a, input logic [2:0] w, input logic v, input logic d);
    int s = int'(a[11:5]);
    upd_req = 1; upd_addr = a; upd_way = w; upd_v = v; upd_d = d; #1;
    chk("upd_acc", {upd_ready, tag_mem_en, tag_rd_wr, tag_addr}, {1'b1, 1'b1, 1'b0, 32'(a[11:5])});
    rv[s][w] = v; rd[s][w] = d; rt[s][w] = a[31:12];
    @(negedge clk); upd_req = 0; upd_addr = $urandom; upd_way = 3'($urandom); #1;
    chk("upd_wr", {upd_ready, lk_ready, upd_done, tag_mem_en, tag_rd_wr, tag_addr, tag_wdata},
        {3'b000, 2'b11, 32'(s), ref_line(s)});
    @(negedge clk); #1;
    chk("upd_done", {upd_done, tag_mem_en}, 2'b10);
  endtask

  task automatic do_lk(input logic [31:0] a);
    lk_req = 1; lk_addr = a; #1;
    chk("lk_acc", {lk_ready, tag_mem_en, tag_rd_wr, tag_addr}, {1'b1, 1'b1, 1'b0, 32'(a[11:5])});
    @(negedge clk); lk_req = 0; lk_addr = $urandom; #1;
    chk("lk_resp", {lk_resp_valid, lk_hit, lk_hit_way, lk_valid_vec, lk_dirty_vec}, ref_lk(a));
  endtask

  task automatic b2b(input int n);
    logic [31:0] prev = 0;
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin lk_req = 1; lk_addr = rand_addr(); end
      else lk_req = 0;
      #1;
      if (k > 0) chk("b2b_resp", {lk_resp_valid, lk_hit, lk_hit_way, lk_valid_vec, lk_dirty_vec}, ref_lk(prev));
      if (k < n) chk("b2b_rdy", {lk_ready, tag_mem_en}, 2'b11);
      prev = lk_addr;
      @(negedge clk);
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    lk_req = 1; upd_req = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out", {lk_ready, upd_ready, lk_resp_valid, lk_hit, lk_hit_way, lk_valid_vec, lk_dirty_vec,
                    upd_done, init_done, tag_mem_en, tag_rd_wr, tag_addr, tag_wdata}, '0);
    lk_req = 0; upd_req = 0; rst_n = 1;
    init_seq();

    do_upd(32'h0000_1A40, 3'd5, 1'b1, 1'b0);
    do_lk(32'h0000_1A40);
    do_lk(32'h0000_2A40);
    b2b(4);

    repeat (80) begin
      if ($urandom_range(0, 1) == 1) do_upd(rand_addr(), 3'($urandom), 1'($urandom), 1'($urandom));
      else do_lk(rand_addr());
    end
    b2b(6);

    a = rand_addr();
    upd_req = 1; upd_addr = a; upd_way = 3'd2; upd_v = 1; upd_d = 1;
    lk_req = 1; lk_addr = a; #1;
    chk("prio_rdy", {lk_ready, upd_ready, tag_addr}, {2'b01, 32'(a[11:5])});
    rv[a[11:5]][2] = 1; rd[a[11:5]][2] = 1; rt[a[11:5]][2] = a[31:12];
    @(negedge clk); upd_req = 0; #1;
    chk("prio_wr", {lk_ready, upd_ready, tag_mem_en, tag_rd_wr, tag_wdata}, {4'b0011, ref_line(int'(a[11:5]))});
    @(negedge clk); #1;
    chk("prio_lk", {upd_done, lk_ready, tag_mem_en, tag_rd_wr, tag_addr}, {4'b1110, 32'(a[11:5])});
    @(negedge clk); lk_req = 0; #1;
    chk("prio_resp", {lk_resp_valid, lk_hit, lk_hit_way, lk_valid_vec, lk_dirty_vec}, ref_lk(a));

    flush_req = 1; upd_req = 1; lk_req = 1; upd_addr = a; lk_addr = a; #1;
    chk("flush_rdy", {lk_ready, upd_ready, tag_mem_en}, 3'b000);
    @(posedge clk); #1;
    flush_req = 0; upd_req = 0; lk_req = 0;
    init_seq();
    do_lk(a);
    do_lk(32'h0000_1A40);

    do_upd(32'h0000_1A40, 3'd5, 1'b1, 1'b0);
    do_lk(32'h0000_1A40);
    upd_req = 1; upd_addr = 32'h0000_2A40; upd_way = 3'd1; upd_v = 1; upd_d = 1;
    @(negedge clk); upd_req = 0; #1;
    chk("abort_wr", {tag_mem_en, tag_rd_wr, tag_addr}, {2'b11, 32'h52});
    rst_n = 0; #1;
    chk("abort_rst", {tag_mem_en, upd_done, init_done, lk_ready, upd_ready}, 5'b0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_nodone", {upd_done, tag_mem_en}, 2'b00);
    end
    rst_n = 1;
    init_seq();
    do_lk(32'h0000_2A40);
    do_lk(32'h0000_1A40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
